// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, source indices and holder entry type for the write-back arbiter
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LINK_REG = 31;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam int NUM_SRC  = 3;
    localparam int SRC_LNK  = 0;
    localparam int SRC_LD   = 1;
    localparam int SRC_ALU  = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_age_matrix.sv
// rtl/wb_age_matrix.sv - age matrix picking the oldest valid holder
// r_age[i][j] = 1 means entry i is older than entry j; only meaningful while both are valid.
module wb_age_matrix
    import wb_pkg::*;
#(
    parameter int N = NUM_SRC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic [N-1:0] i_accept,
    input  logic [N-1:0] i_drain,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);

    logic [N-1:0][N-1:0] r_age;
    logic [N-1:0]        w_oldest;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_oldest[i] = i_valid[i];
            for (int j = 0; j < N; j++) begin
                w_oldest[i] = w_oldest[i] & (r_age[i][j] | (i == j) | !i_valid[j]);
            end
        end
    end

    assign o_grant = w_oldest;

    // Same-cycle accepts: lower index is older; a new entry is younger than anything held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_age <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i_flush || i == j)
                        r_age[i][j] <= 1'b0;
                    else if (i_accept[i] && i_accept[j])
                        r_age[i][j] <= (i < j);
                    else if (i_accept[i])
                        r_age[i][j] <= 1'b0;
                    else if (i_accept[j])
                        r_age[i][j] <= 1'b1;
                    else if (i_drain[i] || i_drain[j])
                        r_age[i][j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - oldest-first arbiter sharing the register-file write port
// Three one-entry holders (link, load, ALU) feed a registered write stage and a pending bitmap.
module regfile_wb_arbiter
    import wb_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_alu_valid,
    input  logic [ADDR_W-1:0]   i_alu_addr,
    input  logic [DATA_W-1:0]   i_alu_data,
    output logic                o_alu_ready,
    input  logic                i_ld_valid,
    input  logic [ADDR_W-1:0]   i_ld_addr,
    input  logic [DATA_W-1:0]   i_ld_data,
    output logic                o_ld_ready,
    input  logic                i_lnk_valid,
    input  logic [DATA_W-1:0]   i_lnk_data,
    output logic                o_lnk_ready,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic [NUM_REGS-1:0] o_pending
);

    wb_entry_t r_hold [NUM_SRC];
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;

    wb_entry_t           w_in [NUM_SRC];
    wb_entry_t           w_sel;
    logic [NUM_SRC-1:0]  w_hold_v;
    logic [NUM_SRC-1:0]  w_grant;
    logic [NUM_SRC-1:0]  w_ready;
    logic [NUM_SRC-1:0]  w_accept;
    logic [NUM_REGS-1:0] w_pending;

    always_comb begin
        w_in[SRC_LNK] = '{valid: i_lnk_valid, addr: ADDR_W'(LINK_REG), data: i_lnk_data};
        w_in[SRC_LD]  = '{valid: i_ld_valid,  addr: i_ld_addr,         data: i_ld_data};
        w_in[SRC_ALU] = '{valid: i_alu_valid, addr: i_alu_addr,        data: i_alu_data};
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_hold_v[i] = r_hold[i].valid;
            w_ready[i]  = !r_hold[i].valid || w_grant[i];
            w_accept[i] = w_in[i].valid && w_ready[i];
        end
    end

    assign o_lnk_ready = w_ready[SRC_LNK];
    assign o_ld_ready  = w_ready[SRC_LD];
    assign o_alu_ready = w_ready[SRC_ALU];

    wb_age_matrix #(
        .N (NUM_SRC)
    ) u_age (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_accept (w_accept),
        .i_drain  (w_grant),
        .i_valid  (w_hold_v),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i])
                w_sel = r_hold[i];
        end
    end

    // A granted R0 write still drains its holder, it just never raises wr_en.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SRC; i++)
                r_hold[i] <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < NUM_SRC; i++)
                r_hold[i].valid <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_accept[i])
                    r_hold[i] <= w_in[i];
                else if (w_grant[i])
                    r_hold[i].valid <= 1'b0;
            end
            r_wr_en <= w_sel.valid && (w_sel.addr != '0);
            if (w_sel.valid) begin
                r_wr_addr <= w_sel.addr;
                r_wr_data <= w_sel.data;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_hold[i].valid)
                w_pending = w_pending | addr_onehot(r_hold[i].addr);
        end
        if (r_wr_en)
            w_pending = w_pending | addr_onehot(r_wr_addr);
        w_pending[0] = 1'b0;
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_pending = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic        clk, rst, flush;
    logic        alu_valid, ld_valid, lnk_valid;
    logic [4:0]  alu_addr, ld_addr;
    logic [31:0] alu_data, ld_data, lnk_data;
    logic        alu_ready, ld_ready, lnk_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending;

    regfile_wb_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_alu_valid (alu_valid),
        .i_alu_addr  (alu_addr),
        .i_alu_data  (alu_data),
        .o_alu_ready (alu_ready),
        .i_ld_valid  (ld_valid),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .o_ld_ready  (ld_ready),
        .i_lnk_valid (lnk_valid),
        .i_lnk_data  (lnk_data),
        .o_lnk_ready (lnk_ready),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] shadow [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdy();
        return {29'd0, lnk_ready, ld_ready, alu_ready};
    endfunction

    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = q.pop_front();
                chk("wr_addr", {27'd0, wr_addr}, {27'd0, mon_e.addr});
                chk("wr_data", wr_data, mon_e.data);
                shadow[wr_addr] = wr_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        lnk_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && q.size() != 0; k++)
            @(negedge clk);
        chk("drain_empty", q.size(), 0);
        smp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        alu_addr = '0; alu_data = '0;
        ld_addr  = '0; ld_data  = '0;
        lnk_data = '0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;

        #2;
        chk("rst_wr_en",   {31'd0, wr_en}, 0);
        chk("rst_wr_addr", {27'd0, wr_addr}, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready",   rdy(), 32'b111);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single ALU write r5
        step();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        q.push_back('{5'd5, 32'hDEADBEEF});
        smp();
        chk("alu_pend_pre", {31'd0, pending[5]}, 0);
        step();
        alu_valid = 1'b0;
        smp();
        chk("alu_pend_hold", {31'd0, pending[5]}, 1);
        chk("alu_wr_en_hold", {31'd0, wr_en}, 0);
        step();
        smp();
        chk("alu_wr_en_stage", {31'd0, wr_en}, 1);
        chk("alu_wr_addr_stage", {27'd0, wr_addr}, 5);
        chk("alu_pend_stage", {31'd0, pending[5]}, 1);
        step();
        smp();
        chk("alu_wr_en_after", {31'd0, wr_en}, 0);
        chk("alu_pend_after", pending, 0);

        // same-cycle lnk/ld/alu
        step();
        lnk_valid = 1'b1; lnk_data = 32'h400;
        ld_valid  = 1'b1; ld_addr  = 5'd8; ld_data  = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h22;
        q.push_back('{5'd31, 32'h400});
        q.push_back('{5'd8,  32'h11});
        q.push_back('{5'd8,  32'h22});
        step();
        idle();
        smp();
        chk("full_ready0", rdy(), 32'b100);
        chk("full_pending", pending, 32'h8000_0100);
        step();
        smp();
        chk("full_ready1", rdy(), 32'b110);
        step();
        smp();
        chk("full_ready2", rdy(), 32'b111);
        wait_drain();

        // ordering across cycles
        step();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        q.push_back('{5'd3, 32'h33});
        step();
        alu_valid = 1'b0;
        lnk_valid = 1'b1; lnk_data = 32'h800;
        ld_valid  = 1'b1; ld_addr  = 5'd3; ld_data = 32'h44;
        q.push_back('{5'd31, 32'h800});
        q.push_back('{5'd3,  32'h44});
        step();
        idle();
        wait_drain();
        chk("order_final_r3",  shadow[3],  32'h44);
        chk("order_final_r31", shadow[31], 32'h800);

        // R0 write consumed silently
        step();
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h55;
        step();
        idle();
        smp();
        chk("r0_pend_hold", pending, 0);
        chk("r0_wr_en_hold", {31'd0, wr_en}, 0);
        step();
        smp();
        chk("r0_pend_stage", pending, 0);
        chk("r0_wr_en_stage", {31'd0, wr_en}, 0);
        chk("r0_ready", rdy(), 32'b111);

        // flush with all holders full plus a same-cycle link accept
        step();
        lnk_valid = 1'b1; lnk_data = 32'h1;
        ld_valid  = 1'b1; ld_addr  = 5'd10; ld_data  = 32'hA;
        alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hB;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        lnk_data = 32'h2; flush = 1'b1;
        smp();
        chk("flush_ready_pre", rdy(), 32'b100);
        chk("flush_pend_pre", pending, 32'h8000_0C00);
        step();
        idle();
        smp();
        chk("flush_wr_en", {31'd0, wr_en}, 0);
        chk("flush_pending", pending, 0);
        chk("flush_ready", rdy(), 32'b111);
        step();
        smp();
        chk("flush_wr_en2", {31'd0, wr_en}, 0);
        step();
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC;
        q.push_back('{5'd12, 32'hC});
        step();
        idle();
        wait_drain();
        chk("flush_after_r12", shadow[12], 32'hC);

        // asynchronous reset with three held entries
        step();
        lnk_valid = 1'b1; lnk_data = 32'h3;
        ld_valid  = 1'b1; ld_addr  = 5'd13; ld_data  = 32'hD;
        alu_valid = 1'b1; alu_addr = 5'd14; alu_data = 32'hE;
        step();
        idle();
        step();
        chk("pre_rst_wr_en", {31'd0, wr_en}, 1);
        chk("pre_rst_pending", pending, 32'h8000_6000);
        #1 rst = 1'b1;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 0);
        chk("arst_wr_addr", {27'd0, wr_addr}, 0);
        chk("arst_pending", pending, 0);
        chk("arst_ready", rdy(), 32'b111);
        step();
        step();
        rst = 1'b0;
        step();
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h77;
        q.push_back('{5'd1, 32'h77});
        step();
        idle();
        wait_drain();
        chk("post_rst_r1", shadow[1], 32'h77);
        chk("post_rst_r13", shadow[13], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
